// File: rtl/uart_pkg.sv
// Shared state encoding, register offsets and STATUS layout for the UART
// transmitter (and a future receiver).
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [31:0] DATA_OFS   = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_OCC_LSB = 4;

  function automatic logic [3:0] occ_sat(input int unsigned n);
    return (n > 15) ? 4'hF : 4'(n);
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core store-path view of the UART: byte enables, ALU address, rs2 data and
// the registered STATUS read-back.
interface mmio_uart_tx_if;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, addr, wdata, input rdata);
  modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop frees the
// slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA write pushes a byte into the FIFO,
// STATUS reads back FIFO/FSM state and clears sticky overflow on write.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_4004,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mmio_uart_tx_if.slave  bus,
  output logic           tx_o,
  output logic           irq_o
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam int OW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_any, hit_data, hit_status, push, pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [OW-1:0] fifo_count;
  logic          ovf_q, ovf_d;
  logic [31:0]   status, rdata_q;
  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          tc;
  logic          unused_wdata;

  assign wr_any       = |bus.we;
  assign hit_data     = (bus.addr == BASE_ADDR + DATA_OFS);
  assign hit_status   = (bus.addr == BASE_ADDR + STATUS_OFS);
  assign push         = wr_any && hit_data && bus.we[0];
  assign unused_wdata = ^bus.wdata[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus.wdata[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A push into a full FIFO is lost only if the transmitter is not draining it this cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_any && hit_status && bus.wdata[STAT_OVF]) ovf_d = 1'b0;
    if (push && fifo_full && !pop)                   ovf_d = 1'b1;
  end

  always_comb begin
    status                       = '0;
    status[STAT_FULL]            = fifo_full;
    status[STAT_EMPTY]           = fifo_empty;
    status[STAT_BUSY]            = (state_q != ST_IDLE);
    status[STAT_OVF]             = ovf_q;
    status[STAT_OCC_LSB +: 4]    = occ_sat(32'(fifo_count));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      rdata_q <= hit_status ? status : 32'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tc = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          state_d = ST_START;
          shift_d = fifo_dout;
        end
      end
      ST_START: if (tc) begin
        state_d = ST_DATA;
        cnt_d   = '0;
        idx_d   = '0;
      end
      ST_DATA: if (tc) begin
        cnt_d = '0;
        idx_d = idx_q + 1'b1;
        if (idx_q == 3'd7) state_d = ST_STOP;
      end
      ST_STOP: if (tc) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // tx is computed from the next state so the registered line lines up with state_q.
  always_comb begin
    pop = (state_q == ST_IDLE) && !fifo_empty;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[idx_d];
      default:  tx_d = 1'b1;
    endcase
  end

  assign bus.rdata = rdata_q;
  assign tx_o      = tx_q;
  assign irq_o     = fifo_empty && (state_q == ST_IDLE);
endmodule
